clk_div_bank: RTL and testbench

- Multi-channel programmable clock divider that derives NUM_CH slower clocks from one PLL output clock.
- Successor to the single fixed-ratio post-divider: per-channel runtime ratio, glitch-free ratio changes applied only at period boundaries, per-channel lock indication, and a config handshake.
- Sits downstream of the PLL and feeds peripheral clock domains.

---
 rtl/clk_div_bank_pkg.sv | 26 ++
 rtl/clk_div_channel.sv | 71 +++++++
 rtl/clk_div_bank.sv | 64 ++++++
 tb/tb_clk_div_bank.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_bank_pkg.sv
// Shared types for the clock divider bank.
// div_t is the divide-ratio type. ch_state_t holds everything one channel
// keeps between edges: active ratio, pending ratio with its flag, period
// counter and lock counter.
package clk_div_bank_pkg;

  localparam int DIV_BITS = 8;

  typedef logic [DIV_BITS-1:0] div_t;

  // Ratios below this value disable a channel.
  localparam div_t MIN_DIV = div_t'(2);

  typedef struct packed {
    div_t active;
    div_t pend_div;
    logic pend_vld;
    div_t cnt;
    div_t lock_cnt;
  } ch_state_t;

  function automatic logic div_on(div_t d);
    return d >= MIN_DIV;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, boundary-aligned ratio apply, lock.
// Ports:
//   clk, rst_n  source clock, async active-low reset
//   we, div     load div as the pending ratio (only issued when !pending)
//   pending     a config is waiting for the next period boundary
//   div_clk     divided clock, straight from a flop
//   tick        high for the first source cycle of each period
//   lock        ratio unchanged for LOCK_PERIODS completed periods
module clk_div_channel
  import clk_div_bank_pkg::*;
#(
  parameter int LOCK_PERIODS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  div_t div,
  output logic pending,
  output logic div_clk,
  output logic tick,
  output logic lock
);

  localparam div_t LOCK_N = div_t'(LOCK_PERIODS);

  ch_state_t st, nxt;
  logic      run, wrap;

  always_comb begin
    nxt  = st;
    run  = div_on(st.active);
    wrap = run && (st.cnt == st.active - div_t'(1));
    // A pending ratio only lands at the wrap edge, so the running period
    // always finishes; an idle channel has no period to finish.
    if (st.pend_vld && (!run || wrap)) begin
      nxt.active   = st.pend_div;
      nxt.pend_vld = 1'b0;
      nxt.cnt      = '0;
      nxt.lock_cnt = '0;
    end else if (wrap) begin
      nxt.cnt = '0;
      if (st.lock_cnt < LOCK_N) nxt.lock_cnt = st.lock_cnt + div_t'(1);
    end else if (run) begin
      nxt.cnt = st.cnt + div_t'(1);
    end
    // The pend flag is sampled above from the old state, so a config
    // accepted on a wrap edge waits for the following wrap.
    if (we) begin
      nxt.pend_div = div;
      nxt.pend_vld = 1'b1;
    end
  end

  // Outputs decode the next state so they line up with the cnt register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= '0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
      lock    <= 1'b0;
    end else begin
      st      <= nxt;
      div_clk <= div_on(nxt.active) && (nxt.cnt < (nxt.active >> 1));
      tick    <= div_on(nxt.active) && (nxt.cnt == '0);
      lock    <= div_on(nxt.active) && (nxt.lock_cnt >= LOCK_N);
    end
  end

  assign pending = st.pend_vld;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider fed from the PLL output.
// Ports:
//   clk_i, arst_ni         source clock, async active-low reset
//   cfg_valid_i/ready_o    config handshake
//   cfg_ch_i, cfg_div_i    target channel and new ratio (D<2 disables)
//   cfg_err_o              one-cycle pulse after a request to a missing channel
//   clk_o, tick_o, lock_o  per-channel divided clock, period tick, lock
module clk_div_bank
  import clk_div_bank_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int DIV_W        = DIV_BITS,
  parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int LOCK_PERIODS = 4
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  output logic              cfg_err_o,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] lock_o
);

  // Channel state is typed from the package, so the port width must match.
  if (DIV_W != DIV_BITS) begin : g_bad_div_w
    $error("clk_div_bank: DIV_W must equal clk_div_bank_pkg::DIV_BITS");
  end

  logic [NUM_CH-1:0] hit, pending, we;
  logic              ch_ok;

  // One-hot decode; an out-of-range channel hits nothing, so it is always
  // ready and simply dropped.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) hit[i] = (cfg_ch_i == CH_W'(i));
    ch_ok       = |hit;
    cfg_ready_o = ~|(hit & pending);
    we          = {NUM_CH{cfg_valid_i}} & hit & ~pending;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) cfg_err_o <= 1'b0;
    else          cfg_err_o <= cfg_valid_i && !ch_ok;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(.LOCK_PERIODS(LOCK_PERIODS)) u_ch (
      .clk     (clk_i),
      .rst_n   (arst_ni),
      .we      (we[g]),
      .div     (div_t'(cfg_div_i)),
      .pending (pending[g]),
      .div_clk (clk_o[g]),
      .tick    (tick_o[g]),
      .lock    (lock_o[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank (NUM_CH=3, DIV_W=8, LOCK_PERIODS=4).
module tb_clk_div_bank;

  localparam int NCH = 3;

  logic           clk = 1'b0;
  logic           rst_n, valid, ready, err;
  logic [1:0]     ch;
  logic [7:0]     div;
  logic [NCH-1:0] co, to, lo;

  int    total = 0;
  int    bad   = 0;
  string tag;

  typedef struct {
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] l;
  } exp_t;
  exp_t sbq[$];

  // ch, d are stimulus; hi, per, lock_k are hand-derived expectations.
  typedef struct {
    int ch;
    int d;
    int hi;
    int per;
    int lock_k;
  } vec_t;
  vec_t tbl[5];

  clk_div_bank dut (
    .clk_i       (clk),
    .arst_ni     (rst_n),
    .cfg_valid_i (valid),
    .cfg_ready_o (ready),
    .cfg_ch_i    (ch),
    .cfg_div_i   (div),
    .cfg_err_o   (err),
    .clk_o       (co),
    .tick_o      (to),
    .lock_o      (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s %s got=%0h want=%0h @%0t", tag, nm, act, expv, $time);
    end
  endtask

  // Expected entry j: phase p=(ph0+j)%per, clock high for p<hi, tick at p==0,
  // lock from entry lock_k onward.
  task automatic push_pat(input int c, input int n, input int hi, input int per,
                          input int ph0, input int lock_k);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      int p;
      p = (ph0 + j) % per;
      e.c = '0; e.t = '0; e.l = '0;
      e.c[c] = (p < hi);
      e.t[c] = (p == 0);
      e.l[c] = (j >= lock_k);
      sbq.push_back(e);
    end
  endtask

  task automatic push_zero(input int n);
    exp_t e;
    e.c = '0; e.t = '0; e.l = '0;
    for (int j = 0; j < n; j++) sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sbq.size() > 0) begin
      @(negedge clk);
      e = sbq.pop_front();
      chk("clk_o", 32'(co), 32'(e.c));
      chk("tick_o", 32'(to), 32'(e.t));
      chk("lock_o", 32'(lo), 32'(e.l));
    end
  endtask

  // Called at a negedge; request is accepted on the following posedge.
  task automatic cfg(input int c, input int d, input logic exp_rdy);
    valid = 1'b1;
    ch    = 2'(c);
    div   = 8'(d);
    #1 chk("cfg_ready_o", 32'(ready), 32'(exp_rdy));
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    ch    = '0;
    div   = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{0, 4, 2, 4, 16};
    tbl[1] = '{1, 5, 2, 5, 20};
    tbl[2] = '{2, 2, 1, 2, 8};
    tbl[3] = '{0, 7, 3, 7, 28};
    tbl[4] = '{1, 8, 4, 8, 32};

    rst_n = 1'b1; valid = 1'b0; ch = '0; div = '0;
    #1 rst_n = 1'b0;
    #2;
    tag = "reset";
    chk("clk_o", 32'(co), 0);
    chk("tick_o", 32'(to), 0);
    chk("lock_o", 32'(lo), 0);
    chk("cfg_err_o", 32'(err), 0);
    chk("cfg_ready_o", 32'(ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Ratio table: idle channel, apply on the edge after acceptance.
    for (int i = 0; i < 5; i++) begin
      do_reset();
      tag = $sformatf("vec%0d_d%0d", i, tbl[i].d);
      cfg(tbl[i].ch, tbl[i].d, 1'b1);
      push_zero(1);
      push_pat(tbl[i].ch, tbl[i].lock_k + tbl[i].per + 2, tbl[i].hi, tbl[i].per, 0, tbl[i].lock_k);
      drain();
    end

    // Glitch-free change D=10 -> D=4 accepted at cnt=3 of a locked period.
    do_reset();
    tag = "glitch";
    cfg(0, 10, 1'b1);
    push_zero(1);
    push_pat(0, 43, 5, 10, 0, 40);
    drain();
    cfg(0, 4, 1'b1);
    push_pat(0, 7, 5, 10, 3, 0);
    push_pat(0, 20, 2, 4, 0, 16);
    drain();

    // Stall: D=8 running, D=6 pending, D=3 held off until D=6 lands.
    do_reset();
    tag = "stall";
    cfg(2, 8, 1'b1);
    push_zero(1);
    push_pat(2, 10, 4, 8, 0, 32);
    drain();
    cfg(2, 6, 1'b1);
    for (int k = 10; k <= 16; k++) begin
      @(negedge clk);
      if (k == 10) begin
        valid = 1'b1; ch = 2'd2; div = 8'd3;
      end
      #1 chk($sformatf("ready_k%0d", k), 32'(ready), 32'(k == 16));
    end
    @(posedge clk);
    #1 valid = 1'b0;
    push_pat(2, 5, 3, 6, 1, 99);
    push_pat(2, 9, 1, 3, 0, 12);
    drain();

    // Disable ch1 at its boundary, then a request to missing channel 3.
    do_reset();
    tag = "disable";
    cfg(1, 5, 1'b1);
    push_zero(1);
    push_pat(1, 7, 2, 5, 0, 20);
    drain();
    cfg(1, 1, 1'b1);
    push_pat(1, 3, 2, 5, 2, 99);
    push_zero(5);
    drain();
    tag = "err";
    cfg(3, 7, 1'b1);
    @(negedge clk);
    chk("cfg_err_o", 32'(err), 1);
    chk("clk_o", 32'(co), 0);
    @(negedge clk);
    chk("cfg_err_o", 32'(err), 0);
    push_zero(4);
    drain();

    // Reset mid-period with a pending config: immediate clear, config lost.
    do_reset();
    tag = "midreset";
    cfg(0, 4, 1'b1);
    push_zero(1);
    push_pat(0, 4, 2, 4, 0, 16);
    drain();
    cfg(0, 6, 1'b1);
    #1 chk("clk_o_pre", 32'(co), 1);
    rst_n = 1'b0;
    #1;
    chk("clk_o", 32'(co), 0);
    chk("tick_o", 32'(to), 0);
    chk("lock_o", 32'(lo), 0);
    chk("cfg_ready_o", 32'(ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    push_zero(8);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
